// File: rtl/record_arbiter.sv
// Two-source record arbiter feeding a single host-bound sample path.
// Source 0 wins by default; source 1 is guaranteed a slot after BURST back-to-back source 0 grants.
module record_arbiter #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned BURST = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,

  input  logic             src0_rdy,
  input  logic [WIDTH-1:0] src0_sample,
  output logic             src0_req,

  input  logic             src1_rdy,
  input  logic [WIDTH-1:0] src1_sample,
  output logic             src1_req,

  output logic             out_rdy,
  output logic [WIDTH-1:0] out_sample,
  output logic             out_src,
  input  logic             out_req,

  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  localparam logic [7:0] BurstMax = 8'(BURST);

  logic [7:0]       burst_q, burst_d;
  logic             out_rdy_q;
  logic [WIDTH-1:0] out_sample_q;
  logic             out_src_q;
  logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt1_q;

  logic slot_free;
  logic can_grant;
  logic starved;
  logic grant0;
  logic grant1;

  // Grants are gated by reset so no source is popped while reset is held.
  always_comb begin
    slot_free = ~out_rdy_q | out_req;
    can_grant = reset_n & enable & slot_free;
    starved   = (burst_q >= BurstMax);
    grant0    = can_grant & src0_rdy & (~src1_rdy | ~starved);
    grant1    = can_grant & src1_rdy & (~src0_rdy | starved);
  end

  // Burst counter tracks source 0 wins while source 1 waits; frozen while disabled.
  always_comb begin
    burst_d = burst_q;
    if (enable) begin
      if (!src1_rdy) begin
        burst_d = 8'd0;
      end else if (grant1) begin
        burst_d = 8'd0;
      end else if (grant0 && !starved) begin
        burst_d = burst_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      burst_q      <= 8'd0;
      out_rdy_q    <= 1'b0;
      out_sample_q <= '0;
      out_src_q    <= 1'b0;
      gnt_cnt0_q   <= '0;
      gnt_cnt1_q   <= '0;
    end else begin
      burst_q <= burst_d;
      if (grant0) begin
        out_rdy_q    <= 1'b1;
        out_sample_q <= src0_sample;
        out_src_q    <= 1'b0;
        gnt_cnt0_q   <= gnt_cnt0_q + CNT_W'(1);
      end else if (grant1) begin
        out_rdy_q    <= 1'b1;
        out_sample_q <= src1_sample;
        out_src_q    <= 1'b1;
        gnt_cnt1_q   <= gnt_cnt1_q + CNT_W'(1);
      end else if (out_req) begin
        out_rdy_q <= 1'b0;
      end
    end
  end

  assign src0_req   = grant0;
  assign src1_req   = grant1;
  assign out_rdy    = out_rdy_q;
  assign out_sample = out_sample_q;
  assign out_src    = out_src_q;
  assign gnt_cnt0   = gnt_cnt0_q;
  assign gnt_cnt1   = gnt_cnt1_q;

endmodule

// File: tb/tb_record_arbiter.sv
// Directed bench for record_arbiter; a second instance with 4-bit counters covers wrap-around.
module tb_record_arbiter;

  localparam int unsigned WIDTH = 48;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             src0_rdy;
  logic [WIDTH-1:0] src0_sample;
  logic             src1_rdy;
  logic [WIDTH-1:0] src1_sample;
  logic             out_req;

  logic             src0_req, src1_req, out_rdy, out_src;
  logic [WIDTH-1:0] out_sample;
  logic [31:0]      gnt_cnt0, gnt_cnt1;

  logic             w_src0_req, w_src1_req, w_out_rdy, w_out_src;
  logic [WIDTH-1:0] w_out_sample;
  logic [3:0]       w_gnt_cnt0, w_gnt_cnt1;

  int checks = 0;
  int errors = 0;

  record_arbiter #(.WIDTH(WIDTH), .BURST(4), .CNT_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .src0_rdy    (src0_rdy),
    .src0_sample (src0_sample),
    .src0_req    (src0_req),
    .src1_rdy    (src1_rdy),
    .src1_sample (src1_sample),
    .src1_req    (src1_req),
    .out_rdy     (out_rdy),
    .out_sample  (out_sample),
    .out_src     (out_src),
    .out_req     (out_req),
    .gnt_cnt0    (gnt_cnt0),
    .gnt_cnt1    (gnt_cnt1)
  );

  record_arbiter #(.WIDTH(WIDTH), .BURST(4), .CNT_W(4)) dut_w4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .src0_rdy    (src0_rdy),
    .src0_sample (src0_sample),
    .src0_req    (w_src0_req),
    .src1_rdy    (src1_rdy),
    .src1_sample (src1_sample),
    .src1_req    (w_src1_req),
    .out_rdy     (w_out_rdy),
    .out_sample  (w_out_sample),
    .out_src     (w_out_src),
    .out_req     (out_req),
    .gnt_cnt0    (w_gnt_cnt0),
    .gnt_cnt1    (w_gnt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_req(input string tag, input logic e0, input logic e1);
    #1;
    check_eq({tag, "_req0"}, src0_req, e0);
    check_eq({tag, "_req1"}, src1_req, e1);
  endtask

  localparam logic [47:0] RecA = 48'h0000_1234_5678;
  localparam logic [47:0] RecB = 48'hBEEF_0000_0001;
  localparam logic [47:0] RecC = 48'hC0C0_1111_2222;
  localparam logic [47:0] RecD = 48'hD00D_3333_4444;

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b1;
    src0_rdy    = 1'b1;
    src1_rdy    = 1'b1;
    src0_sample = RecC;
    src1_sample = RecD;
    out_req     = 1'b0;

    // Reset held with both sources ready.
    for (int i = 0; i < 3; i++) begin
      check_req("rst_hold", 1'b0, 1'b0);
      tick();
      check_eq("rst_out_rdy", out_rdy, 1'b0);
      check_eq("rst_out_sample", out_sample, 48'h0);
      check_eq("rst_out_src", out_src, 1'b0);
      check_eq("rst_cnt0", gnt_cnt0, 32'd0);
      check_eq("rst_cnt1", gnt_cnt1, 32'd0);
    end

    // First grant after release.
    reset_n     = 1'b1;
    src1_rdy    = 1'b0;
    src0_sample = RecA;
    check_req("first", 1'b1, 1'b0);
    tick();
    check_eq("first_out_rdy", out_rdy, 1'b1);
    check_eq("first_out_sample", out_sample, RecA);
    check_eq("first_out_src", out_src, 1'b0);
    check_eq("first_cnt0", gnt_cnt0, 32'd1);

    // Starvation bound: 0,0,0,0,1 repeating.
    apply_reset();
    src0_rdy    = 1'b1;
    src1_rdy    = 1'b1;
    src0_sample = RecA;
    src1_sample = RecB;
    out_req     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic e1;
      e1 = (i % 5 == 4);
      check_req("starve", ~e1, e1);
      tick();
      check_eq("starve_out_src", out_src, e1);
      check_eq("starve_out_sample", out_sample, e1 ? RecB : RecA);
    end
    check_eq("starve_cnt0", gnt_cnt0, 32'd16);
    check_eq("starve_cnt1", gnt_cnt1, 32'd4);

    // Backpressure: source 1 record held, nothing popped.
    out_req     = 1'b0;
    src0_sample = RecC;
    src1_sample = RecD;
    for (int i = 0; i < 10; i++) begin
      check_req("bp", 1'b0, 1'b0);
      tick();
      check_eq("bp_out_rdy", out_rdy, 1'b1);
      check_eq("bp_out_sample", out_sample, RecB);
    end
    out_req = 1'b1;
    check_req("bp_pop", 1'b1, 1'b0);
    tick();
    check_eq("bp_pop_out_rdy", out_rdy, 1'b1);
    check_eq("bp_pop_out_sample", out_sample, RecC);
    check_eq("bp_pop_out_src", out_src, 1'b0);

    // Enable gating: pop drains, no grants; burst count of 1 is kept.
    enable = 1'b0;
    check_req("en_off_pop", 1'b0, 1'b0);
    tick();
    check_eq("en_off_out_rdy", out_rdy, 1'b0);
    out_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_req("en_off", 1'b0, 1'b0);
      tick();
      check_eq("en_off_idle_rdy", out_rdy, 1'b0);
    end
    enable  = 1'b1;
    out_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic e1;
      e1 = (i == 3);
      check_req("en_on", ~e1, e1);
      tick();
      check_eq("en_on_out_rdy", out_rdy, 1'b1);
      check_eq("en_on_out_src", out_src, e1);
    end

    // Source 1 alone, then source 0 alone, then a contested cycle.
    src0_rdy = 1'b0;
    src1_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_req("s1_only", 1'b0, 1'b1);
      tick();
      check_eq("s1_only_rdy", out_rdy, 1'b1);
      check_eq("s1_only_src", out_src, 1'b1);
    end
    src0_rdy = 1'b1;
    src1_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_req("s0_only", 1'b1, 1'b0);
      tick();
      check_eq("s0_only_rdy", out_rdy, 1'b1);
      check_eq("s0_only_src", out_src, 1'b0);
    end
    src1_rdy = 1'b1;
    check_req("contest", 1'b1, 1'b0);
    tick();
    check_eq("contest_src", out_src, 1'b0);

    // Counter wrap on the 4-bit instance.
    apply_reset();
    src0_rdy    = 1'b1;
    src1_rdy    = 1'b0;
    src0_sample = RecA;
    out_req     = 1'b1;
    repeat (15) tick();
    check_eq("wrap_pre_w4", w_gnt_cnt0, 4'd15);
    check_eq("wrap_pre_w32", gnt_cnt0, 32'd15);
    tick();
    check_eq("wrap_w4", w_gnt_cnt0, 4'd0);
    check_eq("wrap_w32", gnt_cnt0, 32'd16);
    check_eq("wrap_cnt1", gnt_cnt1, 32'd0);

    // Reset mid-stream discards the held record.
    out_req = 1'b0;
    check_eq("mid_pre_rdy", out_rdy, 1'b1);
    reset_n = 1'b0;
    check_req("mid_rst", 1'b0, 1'b0);
    tick();
    check_eq("mid_rst_rdy", out_rdy, 1'b0);
    check_eq("mid_rst_sample", out_sample, 48'h0);
    check_eq("mid_rst_cnt0", gnt_cnt0, 32'd0);
    reset_n  = 1'b1;
    src0_rdy = 1'b0;
    out_req  = 1'b1;
    check_req("mid_post", 1'b0, 1'b0);
    tick();
    check_eq("mid_post_rdy", out_rdy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
